// File: rtl/rvv_backend_decode_seq.sv
// Decode-to-Uop-Queue sequencer: per cycle it chooses how many uops of the head
// instruction(s) to push, splits long instructions, and tracks the resume index.
module rvv_backend_decode_seq #(
    parameter int unsigned NUM_DE_INST     = 2,
    parameter int unsigned NUM_DE_UOP      = 4,
    parameter int unsigned UOP_INDEX_WIDTH = 3,
    parameter int unsigned UOP_CNT_WIDTH   = 4
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic [NUM_DE_INST-1:0]                 pkg_valid,
    input  logic [NUM_DE_INST*UOP_CNT_WIDTH-1:0]   uop_cnt,
    input  logic                                   fifo_full_uq2de,
    input  logic [NUM_DE_UOP-1:0]                  fifo_almost_full_uq2de,
    output logic [UOP_INDEX_WIDTH-1:0]             uop_index_remain,
    output logic [NUM_DE_INST-1:0]                 pop_de2cq,
    output logic [NUM_DE_UOP-1:0]                  push_de2uq,
    output logic [NUM_DE_UOP-1:0]                  push_inst_sel,
    output logic [NUM_DE_UOP*UOP_INDEX_WIDTH-1:0]  push_uop_idx
);

    localparam int unsigned CW = UOP_CNT_WIDTH;
    localparam int unsigned IW = UOP_INDEX_WIDTH;

    logic [IW-1:0] remain_q;
    logic [IW-1:0] remain_d;

    logic [CW-1:0] cap;
    logic          cap_stop;
    logic [CW-1:0] cnt0;
    logic [CW-1:0] cnt1;
    logic [CW-1:0] remain_ext;
    logic [CW-1:0] r0;
    logic [CW-1:0] n0;
    logic [CW-1:0] n1;
    logic [CW-1:0] c1;
    logic [CW-1:0] kk;
    logic          slot1_go;

    assign cnt0             = uop_cnt[0 +: CW];
    assign cnt1             = uop_cnt[CW +: CW];
    assign remain_ext       = CW'(remain_q);
    assign uop_index_remain = remain_q;

    // Free push slots: run of zeros in almost_full starting at bit 0.
    always_comb begin
        cap      = '0;
        cap_stop = 1'b0;
        if (!fifo_full_uq2de) begin
            for (int k = 0; k < NUM_DE_UOP; k++) begin
                if (!cap_stop) begin
                    if (fifo_almost_full_uq2de[k]) begin
                        cap_stop = 1'b1;
                    end else begin
                        cap = cap + CW'(1);
                    end
                end
            end
        end
    end

    always_comb begin
        pop_de2cq     = '0;
        push_de2uq    = '0;
        push_inst_sel = '0;
        push_uop_idx  = '0;
        remain_d      = remain_q;
        r0            = cnt0 - remain_ext;
        n0            = '0;
        n1            = '0;
        c1            = '0;
        kk            = '0;
        slot1_go      = 1'b0;

        if (pkg_valid[0]) begin
            // Illegal head (cnt 0) and an out-of-range resume index both just retire the head.
            if (remain_ext >= cnt0) begin
                pop_de2cq[0] = 1'b1;
                remain_d     = '0;
            end else begin
                n0 = (r0 < cap) ? r0 : cap;
                if (n0 == r0) begin
                    pop_de2cq[0] = 1'b1;
                    remain_d     = '0;
                    c1           = cap - n0;
                    slot1_go     = (NUM_DE_INST > 1) && pkg_valid[NUM_DE_INST > 1 ? 1 : 0]
                                   && (c1 != '0);
                end else begin
                    remain_d = IW'(remain_ext + n0);
                end
            end
        end

        // Second instruction uses the leftover capacity; a partial start makes it next head.
        if (slot1_go) begin
            if (cnt1 == '0) begin
                pop_de2cq[NUM_DE_INST > 1 ? 1 : 0] = 1'b1;
            end else begin
                n1 = (cnt1 < c1) ? cnt1 : c1;
                if (n1 == cnt1) begin
                    pop_de2cq[NUM_DE_INST > 1 ? 1 : 0] = 1'b1;
                end else begin
                    remain_d = IW'(n1);
                end
            end
        end

        for (int k = 0; k < NUM_DE_UOP; k++) begin
            kk = CW'(k);
            if (kk < n0) begin
                push_de2uq[k]              = 1'b1;
                push_inst_sel[k]           = 1'b0;
                push_uop_idx[k*IW +: IW]   = IW'(remain_ext + kk);
            end else if (kk < n0 + n1) begin
                push_de2uq[k]              = 1'b1;
                push_inst_sel[k]           = 1'b1;
                push_uop_idx[k*IW +: IW]   = IW'(kk - n0);
            end
        end

        if (!rst_n) begin
            pop_de2cq     = '0;
            push_de2uq    = '0;
            push_inst_sel = '0;
            push_uop_idx  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            remain_q <= '0;
        end else begin
            remain_q <= remain_d;
        end
    end

endmodule

// File: tb/tb_rvv_backend_decode_seq.sv
// Directed plus model-driven random checks of the decode sequencer, using an expectation queue.
module tb_rvv_backend_decode_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rst_req;
    logic [1:0]  pkg_valid;
    logic [7:0]  uop_cnt;
    logic        fifo_full_uq2de;
    logic [3:0]  fifo_almost_full_uq2de;
    logic [2:0]  uop_index_remain;
    logic [1:0]  pop_de2cq;
    logic [3:0]  push_de2uq;
    logic [3:0]  push_inst_sel;
    logic [11:0] push_uop_idx;

    typedef struct {
        string       tag;
        logic [3:0]  push;
        logic [3:0]  sel;
        logic [11:0] idx;
        logic [1:0]  pop;
        logic [2:0]  rem;
    } exp_t;

    exp_t sb[$];
    int   cq[$];
    int   mrem;
    int   checks     = 0;
    int   failures   = 0;
    int   viol_seen  = 0;

    always #5 clk = ~clk;

    rvv_backend_decode_seq dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .pkg_valid              (pkg_valid),
        .uop_cnt                (uop_cnt),
        .fifo_full_uq2de        (fifo_full_uq2de),
        .fifo_almost_full_uq2de (fifo_almost_full_uq2de),
        .uop_index_remain       (uop_index_remain),
        .pop_de2cq              (pop_de2cq),
        .push_de2uq             (push_de2uq),
        .push_inst_sel          (push_inst_sel),
        .push_uop_idx           (push_uop_idx)
    );

    function automatic logic [11:0] pk(int i3, int i2, int i1, int i0);
        return {3'(i3), 3'(i2), 3'(i1), 3'(i0)};
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs after the falling edge, queue its expectation, then check it.
    task automatic step(string tag, logic [1:0] v, int c0, int c1, logic full, logic [3:0] af,
                        logic [3:0] ep, logic [3:0] es, logic [11:0] ei, logic [1:0] eo, int er);
        exp_t e;
        @(negedge clk);
        rst_n                  = rst_req;
        pkg_valid              = v;
        uop_cnt                = {4'(c1), 4'(c0)};
        fifo_full_uq2de        = full;
        fifo_almost_full_uq2de = af;
        if (rst_req && v[0] && c0 != 0 && er >= c0) viol_seen++;
        e.tag  = tag;
        e.push = ep;
        e.sel  = es;
        e.idx  = ei;
        e.pop  = eo;
        e.rem  = 3'(er);
        sb.push_back(e);
        #2;
        e = sb.pop_front();
        chk({e.tag, ".remain"}, 32'(uop_index_remain), 32'(e.rem));
        chk({e.tag, ".push"},   32'(push_de2uq),       32'(e.push));
        chk({e.tag, ".pop"},    32'(pop_de2cq),        32'(e.pop));
        chk({e.tag, ".sel"},    32'(push_inst_sel),    32'(e.sel));
        chk({e.tag, ".idx"},    32'(push_uop_idx),     32'(e.idx));
    endtask

    // Command-queue model: head pair comes from cq, pops retire entries, mrem is the resume index.
    task automatic rnd_cycle();
        logic [1:0]  v;
        logic        full;
        logic [3:0]  af;
        logic [3:0]  tmp;
        logic [3:0]  ep;
        logic [3:0]  es;
        logic [11:0] ei;
        logic [1:0]  eo;
        int c0, c1, cap, r0, n0, n1, left, slot, nrem;
        while (cq.size() < 2 && $urandom_range(0, 3) != 0) cq.push_back(int'($urandom_range(0, 8)));
        v    = (cq.size() >= 2) ? 2'b11 : (cq.size() == 1) ? 2'b01 : 2'b00;
        c0   = (cq.size() > 0) ? cq[0] : 0;
        c1   = (cq.size() > 1) ? cq[1] : 0;
        full = ($urandom_range(0, 7) == 0);
        tmp  = 4'hF;
        if ($urandom_range(0, 1) == 1) af = tmp << $urandom_range(0, 4);
        else af = 4'($urandom);
        cap = 0;
        if (!full) begin
            for (int k = 0; k < 4; k++) begin
                if (af[k]) break;
                cap++;
            end
        end
        ep = '0; es = '0; ei = '0; eo = '0; slot = 0; nrem = mrem;
        if (v[0]) begin
            if (c0 == 0) begin
                eo[0] = 1'b1;
                nrem  = 0;
            end else begin
                r0 = c0 - mrem;
                n0 = (r0 < cap) ? r0 : cap;
                for (int k = 0; k < n0; k++) begin
                    ep[slot] = 1'b1;
                    ei[3*slot +: 3] = 3'(mrem + k);
                    slot++;
                end
                if (n0 == r0) begin
                    eo[0] = 1'b1;
                    nrem  = 0;
                    left  = cap - n0;
                    if (v[1] && left > 0) begin
                        if (c1 == 0) begin
                            eo[1] = 1'b1;
                        end else begin
                            n1 = (c1 < left) ? c1 : left;
                            for (int k = 0; k < n1; k++) begin
                                ep[slot] = 1'b1;
                                es[slot] = 1'b1;
                                ei[3*slot +: 3] = 3'(k);
                                slot++;
                            end
                            if (n1 == c1) eo[1] = 1'b1;
                            else nrem = n1;
                        end
                    end
                end else begin
                    nrem = mrem + n0;
                end
            end
        end
        step("rnd", v, c0, c1, full, af, ep, es, ei, eo, mrem);
        if (eo[0]) void'(cq.pop_front());
        if (eo[1]) void'(cq.pop_front());
        mrem = nrem;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_req                = 1'b0;
        rst_n                  = 1'b0;
        pkg_valid              = '0;
        uop_cnt                = '0;
        fifo_full_uq2de        = 1'b0;
        fifo_almost_full_uq2de = '0;
        repeat (2) @(negedge clk);
        rst_req = 1'b1;

        // Build up a resume index of 5, then reset in the middle of the split.
        step("split8a",   2'b01, 8, 0, 0, 4'b0000, 4'b1111, 4'b0000, pk(3,2,1,0), 2'b00, 0);
        step("split8b",   2'b01, 8, 0, 0, 4'b1110, 4'b0001, 4'b0000, pk(0,0,0,4), 2'b00, 4);
        rst_req = 1'b0;
        step("rst_hold",  2'b01, 8, 0, 0, 4'b0000, 4'b0000, 4'b0000, pk(0,0,0,0), 2'b00, 5);
        rst_req = 1'b1;
        step("post_rst",  2'b00, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, pk(0,0,0,0), 2'b00, 0);

        step("two_fit",   2'b11, 2, 1, 0, 4'b0000, 4'b0111, 4'b0100, pk(0,0,1,0), 2'b11, 0);
        step("c8_a",      2'b01, 8, 0, 0, 4'b0000, 4'b1111, 4'b0000, pk(3,2,1,0), 2'b00, 0);
        step("c8_b",      2'b01, 8, 0, 0, 4'b0000, 4'b1111, 4'b0000, pk(7,6,5,4), 2'b01, 4);
        step("c3_cap2",   2'b11, 3, 3, 0, 4'b1100, 4'b0011, 4'b0000, pk(0,0,1,0), 2'b00, 0);
        step("c3_resume", 2'b11, 3, 3, 0, 4'b0000, 4'b1111, 4'b1110, pk(2,1,0,2), 2'b11, 2);
        step("s1_part",   2'b11, 3, 5, 0, 4'b0000, 4'b1111, 4'b1000, pk(0,2,1,0), 2'b01, 0);
        step("s1_resume", 2'b01, 5, 0, 0, 4'b0000, 4'b1111, 4'b0000, pk(4,3,2,1), 2'b01, 1);
        step("af_1010",   2'b01, 3, 0, 0, 4'b1010, 4'b0001, 4'b0000, pk(0,0,0,0), 2'b00, 0);
        step("full_hold", 2'b01, 3, 0, 1, 4'b0000, 4'b0000, 4'b0000, pk(0,0,0,0), 2'b00, 1);
        step("af_0101",   2'b01, 3, 0, 0, 4'b0101, 4'b0000, 4'b0000, pk(0,0,0,0), 2'b00, 1);
        step("c3_finish", 2'b01, 3, 0, 0, 4'b0000, 4'b0011, 4'b0000, pk(0,0,2,1), 2'b01, 1);
        step("full_ill",  2'b11, 0, 3, 1, 4'b0000, 4'b0000, 4'b0000, pk(0,0,0,0), 2'b01, 0);
        step("s1_ill",    2'b11, 1, 0, 0, 4'b0000, 4'b0001, 4'b0000, pk(0,0,0,0), 2'b11, 0);
        step("no_left",   2'b11, 4, 2, 0, 4'b0000, 4'b1111, 4'b0000, pk(3,2,1,0), 2'b01, 0);
        step("one_valid", 2'b01, 2, 0, 0, 4'b0000, 4'b0011, 4'b0000, pk(0,0,1,0), 2'b01, 0);

        // Deliberate protocol violation: resume index 2 against a 2-uop head.
        step("viol_set",  2'b01, 8, 0, 0, 4'b1100, 4'b0011, 4'b0000, pk(0,0,1,0), 2'b00, 0);
        step("viol",      2'b11, 2, 1, 0, 4'b0000, 4'b0000, 4'b0000, pk(0,0,0,0), 2'b01, 2);
        step("viol_after",2'b00, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, pk(0,0,0,0), 2'b00, 0);
        chk("viol_count", 32'(viol_seen), 32'd1);

        mrem = 0;
        for (int i = 0; i < 80; i++) rnd_cycle();
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
